// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage between instruction memory and decode.
// Reads 32-bit words, splits them into 16-bit halfwords tagged with their
// halfword PC, buffers them in a small prefetch FIFO and hands them to decode
// under a ready/stall handshake. The branch unit redirects fetch through the
// registered branch/target pair.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   branch, target      redirect request and halfword pointer of new PC
//   stall               decoder cannot accept the head entry this cycle
//   insn_ready          insn/insn_pc valid (FIFO non-empty, no redirect)
//   insn, insn_pc       FIFO head halfword and its halfword pointer
//   mem_addr, mem_read  word-address read request, held until accepted
//   mem_waitrequest     request not accepted this cycle
//   mem_readdata        read data, low half = lower halfword address
//   mem_readdatavalid   read data valid, at most one read outstanding
module core_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [30:0] target,
  input  logic        stall,
  output logic        insn_ready,
  output logic [15:0] insn,
  output logic [30:0] insn_pc,
  output logic [29:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);

  localparam int AW = $clog2(DEPTH);
  // A request is only issued while the FIFO can absorb a full word (two halfwords).
  localparam logic [AW:0] ISSUE_MAX = (AW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [30:0] fetch_pc_q, fetch_pc_d;
  logic [29:0] addr_q, addr_d;
  logic        stale_q, stale_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [15:0] fifo_insn [DEPTH];
  logic [30:0] fifo_pc   [DEPTH];

  logic          push;
  logic          push_two;
  logic          pop;
  logic [AW:0]   n_push;
  logic [AW-1:0] hi_idx;

  // Fetch FSM and fetch pointer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    stale_d    = stale_q;
    push       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!branch && count_q <= ISSUE_MAX) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q[30:1];
          stale_d = 1'b0;
        end
      end
      S_REQ: begin
        // addr_q keeps the request stable even if fetch_pc is redirected.
        if (branch) stale_d = 1'b1;
        if (!mem_waitrequest) begin
          state_d = (stale_q || branch) ? S_DROP : S_WAIT;
          stale_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (branch) begin
          // A response arriving with the branch is the outstanding one: consume it.
          state_d = mem_readdatavalid ? S_IDLE : S_DROP;
        end else if (mem_readdatavalid) begin
          push       = 1'b1;
          state_d    = S_IDLE;
          fetch_pc_d = {fetch_pc_q[30:1] + 30'd1, 1'b0};
        end
      end
      S_DROP: begin
        if (mem_readdatavalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (branch) fetch_pc_d = target;
  end

  // An odd fetch_pc means the lower halfword was skipped by a redirect.
  assign push_two = push && !fetch_pc_q[0];
  assign n_push   = !push ? '0 : (push_two ? (AW+1)'(2) : (AW+1)'(1));
  assign hi_idx   = wr_ptr_q + AW'(push_two);

  assign insn_ready = (count_q != '0) && !branch;
  assign pop        = insn_ready && !stall;
  assign insn       = fifo_insn[rd_ptr_q];
  assign insn_pc    = fifo_pc[rd_ptr_q];
  assign mem_read   = (state_q == S_REQ);
  assign mem_addr   = addr_q;

  // FIFO pointers; a redirect flushes everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + n_push[AW-1:0];
    count_d  = count_q + n_push - (AW+1)'(pop);
    if (branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      stale_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates validity, so stale contents
  // are never observed and the array maps onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      if (push_two) begin
        fifo_insn[wr_ptr_q] <= mem_readdata[15:0];
        fifo_pc[wr_ptr_q]   <= fetch_pc_q;
      end
      fifo_insn[hi_idx] <= mem_readdata[31:16];
      fifo_pc[hi_idx]   <= push_two ? fetch_pc_q + 31'd1 : fetch_pc_q;
    end
  end

endmodule
